// File: rtl/xadc_averager_if.sv
// ----------------------------------------------------------------------------
// xadc_averager_if : BRAM read port and AXI4-Stream result bus of xadc_averager
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface xadc_averager_if;
  logic        bram_porta_clk;
  logic        bram_porta_rst;
  logic        bram_porta_en;
  logic [4:0]  bram_porta_addr;
  logic [15:0] bram_porta_rddata;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    output bram_porta_clk,
    output bram_porta_rst,
    output bram_porta_en,
    output bram_porta_addr,
    input  bram_porta_rddata,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  bram_porta_clk,
    input  bram_porta_rst,
    input  bram_porta_en,
    input  bram_porta_addr,
    output bram_porta_rddata,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

`default_nettype wire

// File: rtl/xadc_averager.sv
// ----------------------------------------------------------------------------
// xadc_averager : polls XADC snapshot BRAM, averages 2^log2 scans per address
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module xadc_averager #(
  parameter int CNTR_WIDTH = 32,
  parameter int AVG_MAX    = 8
) (
  input  wire logic                  aclk,
  input  wire logic                  arst,
  input  wire logic [31:0]           cfg_mask,
  input  wire logic [CNTR_WIDTH-1:0] cfg_period,
  input  wire logic [3:0]            cfg_log2,
  output logic                       sts_overrun,
  xadc_averager_if.master            bus
);

  localparam int              c_acc_w   = 16 + AVG_MAX;
  localparam logic [3:0]      c_avg_max = 4'(AVG_MAX);
  localparam logic [AVG_MAX:0] c_one    = (AVG_MAX+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [CNTR_WIDTH:0]   w_cnt_inc;
  logic                  w_tick;
  logic [4:0]            r_addr;
  logic [4:0]            w_addr_nxt;
  logic [AVG_MAX-1:0]    r_pass;
  logic [AVG_MAX-1:0]    w_pass_nxt;
  logic [31:0]           r_mask;
  logic [3:0]            r_log2;
  logic [3:0]            w_log2_clamped;
  logic                  w_snap;
  logic                  w_pass_last;
  logic [AVG_MAX:0]      w_pass_tgt;
  logic                  w_en;
  logic                  w_tvalid;
  logic                  r_overrun;
  logic                  r_vld_d;
  logic [4:0]            r_addr_d;
  logic                  r_first_d;
  logic [c_acc_w-1:0]    r_acc [32];
  logic [c_acc_w-1:0]    w_acc_base;
  logic [c_acc_w-1:0]    w_acc_sel;
  logic [15:0]           w_avg;

  // Wide increment so a cfg_period at the counter's full range still compares correctly.
  assign w_cnt_inc      = {1'b0, r_cnt} + 1'b1;
  assign w_tick         = (w_cnt_inc >= {1'b0, cfg_period});
  assign w_log2_clamped = (cfg_log2 > c_avg_max) ? c_avg_max : cfg_log2;
  assign w_pass_tgt     = (c_one << r_log2) - c_one;
  assign w_pass_last    = ({1'b0, r_pass} == w_pass_tgt);

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc[CNTR_WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pass_nxt  = r_pass;
    w_snap      = 1'b0;
    w_en        = 1'b0;
    w_tvalid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_snap = (r_pass == '0);
        if (w_tick) begin
          w_state_nxt = S_SCAN;
          w_addr_nxt  = 5'd0;
        end
      end
      S_SCAN: begin
        w_en       = r_mask[r_addr];
        w_addr_nxt = r_addr + 5'd1;
        if (r_addr == 5'd31) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_addr_nxt = 5'd0;
        if (w_pass_last) begin
          w_state_nxt = S_DUMP;
        end else begin
          w_pass_nxt  = r_pass + 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DUMP: begin
        // Disabled addresses are skipped without a beat.
        w_tvalid = r_mask[r_addr];
        if (!r_mask[r_addr] || bus.m_axis_tready) begin
          w_addr_nxt = r_addr + 5'd1;
          if (r_addr == 5'd31) begin
            w_pass_nxt  = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_pass  <= '0;
      r_mask  <= '0;
      r_log2  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_pass  <= w_pass_nxt;
      if (w_snap) begin
        r_mask <= cfg_mask;
        r_log2 <= w_log2_clamped;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_overrun <= 1'b0;
    end else if (w_tick && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  // Read data returns one cycle after en; address and first-pass flag travel with it.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_vld_d   <= 1'b0;
      r_addr_d  <= '0;
      r_first_d <= 1'b0;
    end else begin
      r_vld_d   <= w_en;
      r_addr_d  <= r_addr;
      r_first_d <= (r_pass == '0);
    end
  end

  assign w_acc_base = r_first_d ? '0 : r_acc[r_addr_d];

  // The first pass of a block overwrites, so the array needs no reset.
  always_ff @(posedge aclk) begin
    if (r_vld_d) begin
      r_acc[r_addr_d] <= w_acc_base + {{AVG_MAX{1'b0}}, bus.bram_porta_rddata};
    end
  end

  assign w_acc_sel = r_acc[r_addr];
  assign w_avg     = 16'(w_acc_sel >> r_log2);

  assign bus.bram_porta_clk  = aclk;
  assign bus.bram_porta_rst  = arst;
  assign bus.bram_porta_en   = w_en;
  assign bus.bram_porta_addr = r_addr;
  assign bus.m_axis_tvalid   = w_tvalid;
  assign bus.m_axis_tdata    = w_tvalid ? {11'd0, r_addr, w_avg} : 32'd0;
  assign sts_overrun         = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_xadc_averager.sv
// ----------------------------------------------------------------------------
// tb_xadc_averager : table-driven and randomized checks against a mean-of-reads model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_xadc_averager;

  typedef struct {
    logic [31:0] mask;
    logic [3:0]  lg;
    int          period;
    int          mode;
    int          cycles;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_en;
  } vec_t;

  logic        aclk;
  logic        arst;
  logic [31:0] cfg_mask;
  logic [31:0] cfg_period;
  logic [3:0]  cfg_log2;
  logic        sts_overrun;
  logic        tready;
  logic [15:0] rd_q;

  int          n_pass;
  int          n_checks;
  int          mode;
  int          rdy_mode;
  int          m_log2;
  int          sum  [32];
  int          cnt  [32];
  int          rcnt [32];
  int          en_cnt;
  int          beats;
  logic [31:0] first_t;
  logic [31:0] last_t;
  bit          held;
  logic [31:0] held_data;
  logic [31:0] exp_q [$];
  logic [4:0]  ma;
  logic [15:0] mv;
  vec_t        tv [6];

  xadc_averager_if bif ();

  xadc_averager #(
    .CNTR_WIDTH (32),
    .AVG_MAX    (8)
  ) dut (
    .aclk        (aclk),
    .arst        (arst),
    .cfg_mask    (cfg_mask),
    .cfg_period  (cfg_period),
    .cfg_log2    (cfg_log2),
    .sts_overrun (sts_overrun),
    .bus         (bif)
  );

  assign bif.bram_porta_rddata = rd_q;
  assign bif.m_axis_tready     = tready;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  function automatic logic [15:0] gen(input logic [4:0] a);
    case (mode)
      1: return {3'b000, a, 8'h10};
      2: begin
        case (rcnt[a] % 4)
          0:       return 16'h1000;
          1:       return 16'h1001;
          2:       return 16'h1003;
          default: return 16'h1006;
        endcase
      end
      default: return 16'($urandom);
    endcase
  endfunction

  // BRAM model plus reference: every served read joins that address's running sum;
  // after 2^log2 reads the floor mean is the next expected beat.
  always @(posedge aclk) begin
    if (arst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
        sum[i] = 0; cnt[i] = 0; rcnt[i] = 0;
      end
      en_cnt = 0;
    end else if (bif.bram_porta_en) begin
      ma = bif.bram_porta_addr;
      mv = gen(ma);
      rd_q <= mv;
      chk("en_masked", 32'(cfg_mask[ma]), 32'd1);
      en_cnt++;
      sum[ma] += int'(mv);
      cnt[ma]++;
      rcnt[ma]++;
      if (cnt[ma] == (1 << m_log2)) begin
        exp_q.push_back({11'd0, ma, 16'(sum[ma] >> m_log2)});
        sum[ma] = 0;
        cnt[ma] = 0;
      end
    end
  end

  always @(negedge aclk) begin
    if (arst) begin
      held  = 1'b0;
      beats = 0;
    end else begin
      if (held) begin
        chk("axis_hold_valid", 32'(bif.m_axis_tvalid), 32'd1);
        chk("axis_hold_data", bif.m_axis_tdata, held_data);
      end
      if (bif.m_axis_tvalid && tready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("beat_data", bif.m_axis_tdata, exp_q.pop_front());
        if (beats == 0) first_t = bif.m_axis_tdata;
        last_t = bif.m_axis_tdata;
        beats++;
      end
      held      = bif.m_axis_tvalid && !tready;
      held_data = bif.m_axis_tdata;
    end
  end

  initial begin
    tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] m, input logic [3:0] l, input int p);
    @(posedge aclk);
    #1;
    arst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cfg_mask   = $urandom;
      cfg_log2   = 4'($urandom);
      cfg_period = 32'($urandom_range(0, 200));
      @(posedge aclk);
      #1;
    end
    chk("reset_tdata", bif.m_axis_tdata, 32'd0);
    chk("reset_ctrl", {24'd0, bif.bram_porta_en, bif.m_axis_tvalid, sts_overrun, bif.bram_porta_addr}, 32'd0);
    cfg_mask   = m;
    cfg_log2   = l;
    cfg_period = 32'(p);
    m_log2     = (l > 4'd8) ? 8 : int'(l);
    @(posedge aclk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    int b0;
    n_pass = 0; n_checks = 0; mode = 0; rdy_mode = 1; m_log2 = 0;
    rd_q = '0; arst = 1'b1; cfg_mask = '0; cfg_period = 32'd100; cfg_log2 = '0;

    tv[0] = '{32'h0000_0003, 4'd0, 100, 1, 180, 2,  32'h0000_0010, 32'h0001_0110, 2};
    tv[1] = '{32'h0001_0000, 4'd2, 100, 2, 380, 0,  32'h0,         32'h0,         3};
    tv[2] = '{32'h0001_0000, 4'd2, 100, 2, 475, 1,  32'h0010_1002, 32'h0010_1002, 4};
    tv[3] = '{32'h0000_0000, 4'd0, 100, 0, 380, 0,  32'h0,         32'h0,         0};
    tv[4] = '{32'h8000_0001, 4'd1, 100, 1, 280, 2,  32'h0000_0010, 32'h001F_1F10, 4};
    tv[5] = '{32'hFFFF_FFFF, 4'd0, 100, 1, 180, 32, 32'h0000_0010, 32'h001F_1F10, 32};
    repeat (3) @(posedge aclk);

    for (int i = 0; i < 6; i++) begin
      mode = tv[i].mode;
      rdy_mode = 1;
      do_reset(tv[i].mask, tv[i].lg, tv[i].period);
      run(tv[i].cycles);
      chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(tv[i].exp_beats));
      chk($sformatf("vec%0d_en", i), 32'(en_cnt), 32'(tv[i].exp_en));
      if (tv[i].exp_beats > 0) begin
        chk($sformatf("vec%0d_first", i), first_t, tv[i].exp_first);
        chk($sformatf("vec%0d_last", i), last_t, tv[i].exp_last);
      end
    end

    // Stalled stream with short period: beat held, ticks dropped as overrun.
    mode = 1; rdy_mode = 0;
    do_reset(32'h3, 4'd0, 40);
    run(500);
    chk("bp_overrun", 32'(sts_overrun), 32'd1);
    chk("bp_tvalid", 32'(bif.m_axis_tvalid), 32'd1);
    chk("bp_tdata", bif.m_axis_tdata, 32'h0000_0010);
    b0 = beats;
    rdy_mode = 1;
    run(100);
    chk("bp_delivered", 32'(beats - b0 >= 2), 32'd1);
    chk("bp_overrun_sticky", 32'(sts_overrun), 32'd1);

    // Reset during the third scan of a 4-scan block.
    mode = 2; rdy_mode = 1;
    do_reset(32'h0001_0000, 4'd2, 100);
    run(310);
    chk("midrst_no_beat", 32'(beats), 32'd0);
    do_reset(32'h0001_0000, 4'd2, 100);
    run(475);
    chk("midrst_beats", 32'(beats), 32'd1);
    chk("midrst_avg", last_t, 32'h0010_1002);

    mode = 0;
    do_reset(32'h1, 4'd0, 1);
    run(5);
    chk("period1_overrun", 32'(sts_overrun), 32'd1);

    // log2 above the maximum clamps to 256 scans per average.
    do_reset(32'h20, 4'd15, 40);
    run(10310);
    chk("clamp_beats", 32'(beats), 32'd1);
    chk("clamp_en", 32'(en_cnt), 32'd256);

    for (int it = 0; it < 6; it++) begin
      logic [31:0] rm;
      rm = $urandom;
      rdy_mode = 2;
      do_reset(rm, 4'($urandom_range(0, 2)), $urandom_range(34, 120));
      run(1500);
      chk($sformatf("rand%0d_activity", it), 32'(beats > 0), 32'(rm != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
